// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and access sequencer in front of
//               a single-port data memory. Each grant performs exactly one
//               single-cycle memory read or write (ACCESS), followed by a
//               one-cycle registered response to the winning port (RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;

    // Registered outputs; the memory-facing registers also hold the latched
    // address / write data of the current access during ACCESS.
    logic              r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d;
    logic              r0_rvalid_q, r0_rvalid_d, r1_rvalid_q, r1_rvalid_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;

    logic              arb_req, arb_win, arb_take;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] capture;
    logic              in_access;

    // Round-robin winner selection; a tie goes to the port not served last.
    always_comb begin
        arb_req = r0_req | r1_req;
        arb_win = 1'b0;
        if (r0_req && r1_req) begin
            arb_win = ~last_owner_q;
        end else if (r1_req) begin
            arb_win = 1'b1;
        end
        win_we    = arb_win ? r1_we    : r0_we;
        win_addr  = arb_win ? r1_addr  : r0_addr;
        win_wdata = arb_win ? r1_wdata : r0_wdata;
        arb_take  = arb_req && ((state_q == S_IDLE) || (state_q == S_RESP));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCESS always lasts one cycle, RESP re-arbitrates.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arb_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = arb_req ? S_ACCESS : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched request context.
    always_comb begin
        in_access    = (state_q == S_ACCESS);
        capture      = we_q ? '0 : mem_read_data;
        owner_d      = arb_take ? arb_win : owner_q;
        last_owner_d = arb_take ? arb_win : last_owner_q;
        we_d         = arb_take ? win_we  : we_q;
        r0_gnt_d     = arb_take && !arb_win;
        r1_gnt_d     = arb_take &&  arb_win;
        mem_addr_d   = arb_take ? win_addr : '0;
        mem_wdata_d  = (arb_take && win_we) ? win_wdata : '0;
        mem_we_d     = arb_take &&  win_we;
        mem_rd_d     = arb_take && !win_we;
        r0_rvalid_d  = in_access && !owner_q;
        r1_rvalid_d  = in_access &&  owner_q;
        r0_rdata_d   = (in_access && !owner_q) ? capture : r0_rdata_q;
        r1_rdata_d   = (in_access &&  owner_q) ? capture : r1_rdata_q;
        busy_d       = (state_d != S_IDLE);
    end

    // Output and context registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            r0_gnt_q     <= 1'b0;
            r1_gnt_q     <= 1'b0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            r0_gnt_q     <= r0_gnt_d;
            r1_gnt_q     <= r1_gnt_d;
            r0_rvalid_q  <= r0_rvalid_d;
            r1_rvalid_q  <= r1_rvalid_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
        end
    end

    assign r0_gnt          = r0_gnt_q;
    assign r1_gnt          = r1_gnt_q;
    assign r0_rvalid       = r0_rvalid_q;
    assign r1_rvalid       = r1_rvalid_q;
    assign r0_rdata        = r0_rdata_q;
    assign r1_rdata        = r1_rdata_q;
    assign mem_access_addr = mem_addr_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_write_en    = mem_we_q;
    assign mem_read        = mem_rd_q;
    assign busy            = busy_q;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and access sequencer in front of the single-port 8x32 data memory. Port 0 serves the core load/store path. Port 1 serves a secondary master (debug/DMA loader). The block latches one request per grant, issues exactly one single-cycle memory read or write, then returns a registered response to the winning requester.

Parameters:
ADDR_W, 32, width of requester and memory address buses (memory decodes addr[2:0] only)
DATA_W, 32, width of write/read data

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
r0_req  input  1  port 0 access request (level)
r0_we  input  1  port 0: 1=write, 0=read
r0_addr  input  ADDR_W  port 0 address
r0_wdata  input  DATA_W  port 0 write data
r0_gnt  output  1  port 0 grant pulse (one cycle)
r0_rvalid  output  1  port 0 response pulse (one cycle)
r0_rdata  output  DATA_W  port 0 read data, valid with r0_rvalid
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as port 0, for port 1
mem_access_addr  output  ADDR_W  to memory address
mem_write_data  output  DATA_W  to memory write data
mem_write_en  output  1  to memory write enable
mem_read  output  1  to memory read enable
mem_read_data  input  DATA_W  from memory (combinational read, 0 when mem_read=0)
busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: clk, rst_n fixed as stated; reset is asynchronous, active-low.
- All outputs registered. Reset values are 0 for all outputs. Internal state: state=IDLE, owner=0, last_owner=1, latched addr/wdata/we=0.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration occurs in IDLE and RESP at the rising edge:
  - Neither req: go to / stay in IDLE.
  - Only one req: that port wins.
  - Both req: winner = ~last_owner (round-robin).
  - Winner's we/addr/wdata latched; owner=winner; last_owner=winner; next state ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_access_addr = latched addr; mem_write_data = latched wdata (0 on reads).
  - mem_write_en = latched we; mem_read = ~latched we.
  - rX_gnt=1 for owner only.
  - Requests are not sampled.
  - At the closing edge: write commits in memory; mem_read_data captured into the owner's rdata register (0 for writes); next state RESP.
- RESP (1 cycle):
  - Memory outputs all 0. rX_rvalid=1 for owner, for reads and writes (write ack).
  - rX_rdata holds the captured value until the next response to that port.
  - Non-owner rdata unchanged.
  - Arbitration for the next access happens at the closing edge.
- Requester rule: a requester holds req/we/addr/wdata stable until it sees gnt, and deasserts req in the cycle after gnt unless requesting again. req high during the RESP cycle counts as a new request.
- Latency: req sampled at edge E → gnt in cycle E+1 → rvalid in cycle E+2.
- Throughput: one access per 2 cycles sustained (ACCESS/RESP alternation). Both ports saturating alternate strictly 0,1,0,1…; first tie after reset goes to port 0.
- Address: full ADDR_W passed through; aliasing mod 8 is the memory's behaviour and is not checked here.
- mem_write_en and mem_read are never high simultaneously. Never more than one gnt or rvalid high per cycle.
- Reset mid-operation: assertion in any state immediately (asynchronously) zeroes all outputs including mem_write_en. A write whose ACCESS edge has not occurred is dropped. After release, FSM is in IDLE with last_owner=1.

Test Plan:
- Port 0 write 0xDEADBEEF to addr 3, then read addr 3 → mem_write_en pulse 1 cycle with addr=3; read gives r0_rvalid with r0_rdata=0xDEADBEEF two cycles after read req sampled.
- Both ports request reads in the same cycle after reset (r0 addr 1, r1 addr 2) → r0_gnt first, r1_gnt two cycles later; each rvalid only on its own port with correct data.
- Both ports hold req continuously for 8 accesses → grants alternate 0,1,0,1…, one ACCESS every 2 cycles, busy stays 1.
- Write from port 1 → r1_rvalid pulses with r1_rdata=0; r0_rdata keeps its previous value.
- Assert rst_n=0 during ACCESS of a write of 0x12345678 → mem_write_en drops at once, no rvalid. After release, IDLE and first tie granted to port 0.
- Port 0 read of addr 9 after a write of 0xA5A5A5A5 to addr 1 → mem_access_addr=9 driven unmodified; r0_rdata=0xA5A5A5A5.
